// File: rtl/mod_burst_ctrl_pkg.sv
// mod_burst_ctrl_pkg
// Shared definitions for the burst controller.
//   - state_e        : sequencer states (IDLE, SYNC, BURST, GAP)
//   - *_DEF          : default field widths of the mod-params message
//   - MSG_*_OFF      : bit offsets of each field inside the UART mod-params
//                      message (half-period, burst, gap, repeat; LSB first)
//   - DEFAULT_HP_VAL : half-period loaded into the active config at reset
//   - is_busy()      : true for every state except IDLE
package mod_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_BURST = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int unsigned HP_W_DEF       = 16;
  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned DEFAULT_HP_VAL = 4;

  // UART mod-params message layout: {repeat, gap, burst, half_period}
  localparam int unsigned MSG_HP_OFF     = 0;
  localparam int unsigned MSG_BURST_OFF  = MSG_HP_OFF + HP_W_DEF;
  localparam int unsigned MSG_GAP_OFF    = MSG_BURST_OFF + CNT_W_DEF;
  localparam int unsigned MSG_REPEAT_OFF = MSG_GAP_OFF + CNT_W_DEF;
  localparam int unsigned MSG_W          = MSG_REPEAT_OFF + 1;

  function automatic logic is_busy(input state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/mod_burst_ctrl_cycle_downcounter.sv
// cycle_downcounter
// Loadable down-counter used to time one phase (burst or gap) in clk cycles.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : load load_value (has priority over en)
//   en          : decrement by one; holds at zero, never wraps
//   load_value  : value to load, CNT_W bits
//   last        : current value equals 1, i.e. this is the final cycle
module cycle_downcounter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_value,
  output logic             last
);

  logic [CNT_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (en && (value_q != '0)) begin
      value_d = value_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  // Comparing against 1 lets a load of N give exactly N enabled cycles,
  // so the full range 1 .. 2^CNT_W-1 is usable.
  assign last = (value_q == CNT_W'(1));

endmodule

// File: rtl/mod_burst_ctrl.sv
// mod_burst_ctrl
// Sequences the modulator as repeating bursts: SYNC (phase resync), BURST
// (carrier gated on for burst_cycles), GAP (off for gap_cycles).
// Configuration arrives over a valid/ready handshake into a shadow register
// and is promoted to the active set only in IDLE or on entry to SYNC, so the
// carrier parameters never change mid-burst.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cfg_valid / cfg_ready      : config handshake (ready = shadow empty)
//   cfg_half_period            : modulator cycles-per-half-period (HP_W)
//   cfg_burst_cycles/_gap_cycles: phase lengths in clk cycles (CNT_W)
//   cfg_repeat                 : 1 = continuous bursts, 0 = single burst
//   cmd_start / cmd_stop       : one-cycle command pulses
//   mod_params                 : active half-period to the modulator
//   mod_n_reset                : modulator reset, active-low (low in SYNC)
//   mod_in                     : modulator data gate (high in BURST)
//   busy                       : not IDLE
//   burst_done                 : one-cycle pulse after each BURST
//   burst_count                : (only with MOD_BURST_CTRL_BURST_COUNT_EN)
//                                saturating count of burst_done pulses
// All outputs are registered.
module mod_burst_ctrl
  import mod_burst_ctrl_pkg::*;
#(
  parameter int unsigned      HP_W       = HP_W_DEF,
  parameter int unsigned      CNT_W      = CNT_W_DEF,
  parameter logic [HP_W-1:0]  DEFAULT_HP = HP_W'(DEFAULT_HP_VAL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [HP_W-1:0]  cfg_half_period,
  input  logic [CNT_W-1:0] cfg_burst_cycles,
  input  logic [CNT_W-1:0] cfg_gap_cycles,
  input  logic             cfg_repeat,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  output logic [HP_W-1:0]  mod_params,
  output logic             mod_n_reset,
  output logic             mod_in,
  output logic             busy,
  output logic             burst_done
`ifdef MOD_BURST_CTRL_BURST_COUNT_EN
  ,
  output logic [CNT_W-1:0] burst_count
`endif
);

  state_e state_q, state_d;

  // Shadow (handshake side) and active (sequencer side) configuration
  logic             shadow_full_q, shadow_full_d;
  logic [HP_W-1:0]  shadow_hp_q, shadow_hp_d;
  logic [CNT_W-1:0] shadow_burst_q, shadow_burst_d;
  logic [CNT_W-1:0] shadow_gap_q, shadow_gap_d;
  logic             shadow_repeat_q, shadow_repeat_d;
  logic [HP_W-1:0]  act_hp_q, act_hp_d;
  logic [CNT_W-1:0] act_burst_q, act_burst_d;
  logic [CNT_W-1:0] act_gap_q, act_gap_d;
  logic             act_repeat_q, act_repeat_d;

  logic stop_pending_q, stop_pending_d;
  logic cfg_ready_q, cfg_ready_d;
  logic mod_n_reset_q, mod_n_reset_d;
  logic mod_in_q, mod_in_d;
  logic busy_q, busy_d;
  logic burst_done_q, burst_done_d;

  logic   transfer, promote, stop_eff;
  logic   burst_last, gap_last;
  state_e after_burst_st, after_gap_st;

  // Both counters load in SYNC from the freshly promoted active config.
  cycle_downcounter #(.CNT_W(CNT_W)) u_burst_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (state_q == ST_SYNC),
    .en         (state_q == ST_BURST),
    .load_value (act_burst_q),
    .last       (burst_last)
  );

  cycle_downcounter #(.CNT_W(CNT_W)) u_gap_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (state_q == ST_SYNC),
    .en         (state_q == ST_GAP),
    .load_value (act_gap_q),
    .last       (gap_last)
  );

  // Next-state logic; zero-length phases are skipped by chaining the
  // "what comes after" decisions.
  always_comb begin
    stop_eff       = stop_pending_q | cmd_stop;
    after_gap_st   = (act_repeat_q && !stop_eff) ? ST_SYNC : ST_IDLE;
    after_burst_st = ((act_gap_q != '0) && !stop_eff) ? ST_GAP : after_gap_st;
    state_d        = state_q;
    burst_done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // stop wins over a simultaneous start
        if (cmd_start && !cmd_stop) begin
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        state_d = (act_burst_q != '0) ? ST_BURST : after_burst_st;
      end
      ST_BURST: begin
        if (burst_last) begin
          burst_done_d = 1'b1;
          state_d      = after_burst_st;
        end
      end
      ST_GAP: begin
        // a stop during the gap lets it run out, then returns to IDLE
        if (gap_last) begin
          state_d = after_gap_st;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Config handshake and promotion
  always_comb begin
    transfer = cfg_valid && cfg_ready_q;
    // Entry into SYNC is the only in-flight boundary; IDLE promotes freely.
    promote  = shadow_full_q && ((state_q == ST_IDLE) || (state_d == ST_SYNC));

    shadow_hp_d     = shadow_hp_q;
    shadow_burst_d  = shadow_burst_q;
    shadow_gap_d    = shadow_gap_q;
    shadow_repeat_d = shadow_repeat_q;
    if (transfer) begin
      shadow_hp_d     = cfg_half_period;
      shadow_burst_d  = cfg_burst_cycles;
      shadow_gap_d    = cfg_gap_cycles;
      shadow_repeat_d = cfg_repeat;
    end
    // A transfer in the promotion cycle refills the shadow immediately.
    shadow_full_d = transfer | (shadow_full_q & ~promote);
    cfg_ready_d   = ~shadow_full_d;

    act_hp_d     = act_hp_q;
    act_burst_d  = act_burst_q;
    act_gap_d    = act_gap_q;
    act_repeat_d = act_repeat_q;
    if (promote) begin
      act_hp_d     = shadow_hp_q;
      act_burst_d  = shadow_burst_q;
      act_gap_d    = shadow_gap_q;
      act_repeat_d = shadow_repeat_q;
    end
  end

  // Registered outputs are derived from the next state so they line up
  // with the state register.
  always_comb begin
    stop_pending_d = stop_pending_q;
    if (state_d == ST_IDLE) begin
      stop_pending_d = 1'b0;
    end else if ((state_q != ST_IDLE) && cmd_stop) begin
      stop_pending_d = 1'b1;
    end
    mod_n_reset_d = (state_d != ST_SYNC);
    mod_in_d      = (state_d == ST_BURST);
    busy_d        = is_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      shadow_full_q   <= 1'b0;
      shadow_hp_q     <= '0;
      shadow_burst_q  <= '0;
      shadow_gap_q    <= '0;
      shadow_repeat_q <= 1'b0;
      act_hp_q        <= DEFAULT_HP;
      act_burst_q     <= '0;
      act_gap_q       <= '0;
      act_repeat_q    <= 1'b0;
      stop_pending_q  <= 1'b0;
      cfg_ready_q     <= 1'b1;
      mod_n_reset_q   <= 1'b0;
      mod_in_q        <= 1'b0;
      busy_q          <= 1'b0;
      burst_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      shadow_full_q   <= shadow_full_d;
      shadow_hp_q     <= shadow_hp_d;
      shadow_burst_q  <= shadow_burst_d;
      shadow_gap_q    <= shadow_gap_d;
      shadow_repeat_q <= shadow_repeat_d;
      act_hp_q        <= act_hp_d;
      act_burst_q     <= act_burst_d;
      act_gap_q       <= act_gap_d;
      act_repeat_q    <= act_repeat_d;
      stop_pending_q  <= stop_pending_d;
      cfg_ready_q     <= cfg_ready_d;
      mod_n_reset_q   <= mod_n_reset_d;
      mod_in_q        <= mod_in_d;
      busy_q          <= busy_d;
      burst_done_q    <= burst_done_d;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign mod_params  = act_hp_q;
  assign mod_n_reset = mod_n_reset_q;
  assign mod_in      = mod_in_q;
  assign busy        = busy_q;
  assign burst_done  = burst_done_q;

`ifdef MOD_BURST_CTRL_BURST_COUNT_EN
  logic [CNT_W-1:0] burst_count_q, burst_count_d;

  // Updates on the same edge that raises burst_done, so the two agree.
  always_comb begin
    burst_count_d = burst_count_q;
    if ((state_q == ST_IDLE) && cmd_start && !cmd_stop) begin
      burst_count_d = '0;
    end else if (burst_done_d && (burst_count_q != '1)) begin
      burst_count_d = burst_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_count_q <= '0;
    end else begin
      burst_count_q <= burst_count_d;
    end
  end

  assign burst_count = burst_count_q;
`endif

endmodule

// File: tb/tb_mod_burst_ctrl.sv
// tb_mod_burst_ctrl
// Scoreboard bench for mod_burst_ctrl. Each scenario pushes hand-derived,
// cycle-tagged expectations; a monitor on the falling edge pops the entries
// due for the current cycle and compares them with the DUT outputs.
// Set MOD_BURST_CTRL_BURST_COUNT_EN to also exercise burst_count.
module tb_mod_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_half_period;
  logic [15:0] cfg_burst_cycles;
  logic [15:0] cfg_gap_cycles;
  logic        cfg_repeat;
  logic        cmd_start;
  logic        cmd_stop;
  logic [15:0] mod_params;
  logic        mod_n_reset;
  logic        mod_in;
  logic        busy;
  logic        burst_done;
`ifdef MOD_BURST_CTRL_BURST_COUNT_EN
  logic [15:0] burst_count;
`endif

  mod_burst_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_half_period  (cfg_half_period),
    .cfg_burst_cycles (cfg_burst_cycles),
    .cfg_gap_cycles   (cfg_gap_cycles),
    .cfg_repeat       (cfg_repeat),
    .cmd_start        (cmd_start),
    .cmd_stop         (cmd_stop),
    .mod_params       (mod_params),
    .mod_n_reset      (mod_n_reset),
    .mod_in           (mod_in),
    .busy             (busy),
    .burst_done       (burst_done)
`ifdef MOD_BURST_CTRL_BURST_COUNT_EN
    ,
    .burst_count      (burst_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          sig;   // 1: output vector check, 0: burst_count check
    logic [4:0]  vec;   // {mod_n_reset, mod_in, busy, burst_done, cfg_ready}
    logic [15:0] hp;
    int          bc;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic push_sig(input int c0, input int c1, input logic nrst, input logic mi,
                          input logic bz, input logic dn, input logic rdy,
                          input logic [15:0] hp, input string nm);
    for (int c = c0; c <= c1; c++) begin
      exp_t e;
      e.cyc = c; e.sig = 1'b1; e.vec = {nrst, mi, bz, dn, rdy};
      e.hp = hp; e.bc = 0; e.nm = nm;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_bc(input int c, input int bc, input string nm);
    exp_t e;
    e.cyc = c; e.sig = 1'b0; e.vec = '0; e.hp = '0; e.bc = bc; e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every expectation due in this cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] got;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e   = exp_q.pop_front();
      got = {mod_n_reset, mod_in, busy, burst_done, cfg_ready};
      checks++;
      if (e.cyc < cyc) begin
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.nm, e.cyc, cyc);
      end else if (e.sig) begin
        if (got !== e.vec || mod_params !== e.hp)
          $display("FAIL %s cyc=%0d: got nrst/in/busy/done/rdy=%b hp=%0d, want %b hp=%0d",
                   e.nm, cyc, got, mod_params, e.vec, e.hp);
        else begin
          passed++;
          $display("ok   %s cyc=%0d vec=%b hp=%0d", e.nm, cyc, got, mod_params);
        end
      end else begin
`ifdef MOD_BURST_CTRL_BURST_COUNT_EN
        if (burst_count !== 16'(e.bc))
          $display("FAIL %s cyc=%0d: got burst_count=%0d, want %0d", e.nm, cyc, burst_count, e.bc);
        else begin
          passed++;
          $display("ok   %s cyc=%0d burst_count=%0d", e.nm, cyc, burst_count);
        end
`else
        $display("FAIL %s: burst_count check without the feature", e.nm);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic write_cfg(input logic [15:0] hp, input logic [15:0] b,
                           input logic [15:0] g, input logic r);
    cfg_valid = 1'b1; cfg_half_period = hp; cfg_burst_cycles = b;
    cfg_gap_cycles = g; cfg_repeat = r;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1; step(); cmd_start = 1'b0;
  endtask

  task automatic pulse_stop();
    cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
  endtask

  int c, t;

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_half_period = '0; cfg_burst_cycles = '0;
    cfg_gap_cycles = '0; cfg_repeat = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;

    // Reset values, then IDLE
    step();
    push_sig(1, 2, 0, 0, 0, 0, 1, 16'd4, "reset_vals");
    push_sig(3, 3, 1, 0, 0, 0, 1, 16'd4, "idle_after_reset");
    step();
    reset = 1'b0;
    step_to(4);

    // 1: default half-period, burst 5, gap 3, single shot
    c = cyc; t = c + 2;
    push_sig(c+1,  c+1,  1, 0, 0, 0, 0, 16'd4, "s1_cfg_taken");
    push_sig(c+2,  c+2,  1, 0, 0, 0, 1, 16'd4, "s1_cfg_promoted");
    push_sig(t+1,  t+1,  0, 0, 1, 0, 1, 16'd4, "s1_sync");
    push_sig(t+2,  t+6,  1, 1, 1, 0, 1, 16'd4, "s1_burst");
    push_sig(t+7,  t+7,  1, 0, 1, 1, 1, 16'd4, "s1_gap_done");
    push_sig(t+8,  t+9,  1, 0, 1, 0, 1, 16'd4, "s1_gap");
    push_sig(t+10, t+11, 1, 0, 0, 0, 1, 16'd4, "s1_idle");
    write_cfg(16'd4, 16'd5, 16'd3, 1'b0);
    step_to(t); pulse_start();
    step_to(t+12);

    // 2: repeating, hp 8; new hp 12 written mid-burst, applied at next SYNC
    c = cyc; t = c + 2;
    push_sig(c+1,  c+1,  1, 0, 0, 0, 0, 16'd4,  "s2_cfg_taken");
    push_sig(c+2,  c+2,  1, 0, 0, 0, 1, 16'd8,  "s2_cfg_promoted");
    push_sig(t+1,  t+1,  0, 0, 1, 0, 1, 16'd8,  "s2_sync");
    push_sig(t+2,  t+3,  1, 1, 1, 0, 1, 16'd8,  "s2_burst");
    push_sig(t+4,  t+5,  1, 1, 1, 0, 0, 16'd8,  "s2_burst_shadow_full");
    push_sig(t+6,  t+6,  1, 0, 1, 1, 0, 16'd8,  "s2_gap_done");
    push_sig(t+7,  t+7,  1, 0, 1, 0, 0, 16'd8,  "s2_gap");
    push_sig(t+8,  t+8,  0, 0, 1, 0, 1, 16'd12, "s2_resync_new_hp");
    push_sig(t+9,  t+12, 1, 1, 1, 0, 1, 16'd12, "s2_burst2");
    push_sig(t+13, t+13, 1, 0, 0, 1, 1, 16'd12, "s2_stop_idle_done");
    push_sig(t+14, t+14, 1, 0, 0, 0, 1, 16'd12, "s2_idle");
    write_cfg(16'd8, 16'd4, 16'd2, 1'b1);
    step_to(t); pulse_start();
    step_to(t+3); write_cfg(16'd12, 16'd4, 16'd2, 1'b1);
    step_to(t+9); pulse_stop();
    step_to(t+15);

    // 3: stop on cycle 2 of a 10-cycle burst
    c = cyc; t = c + 2;
    push_sig(c+1,  c+1,  1, 0, 0, 0, 0, 16'd12, "s3_cfg_taken");
    push_sig(c+2,  c+2,  1, 0, 0, 0, 1, 16'd12, "s3_cfg_promoted");
    push_sig(t+1,  t+1,  0, 0, 1, 0, 1, 16'd12, "s3_sync");
    push_sig(t+2,  t+11, 1, 1, 1, 0, 1, 16'd12, "s3_burst");
    push_sig(t+12, t+12, 1, 0, 0, 1, 1, 16'd12, "s3_stop_idle_done");
    push_sig(t+13, t+13, 1, 0, 0, 0, 1, 16'd12, "s3_idle");
    write_cfg(16'd12, 16'd10, 16'd5, 1'b1);
    step_to(t); pulse_start();
    step_to(t+3); pulse_stop();
    step_to(t+14);

    // 4: burst 0, gap 3
    c = cyc; t = c + 2;
    push_sig(c+1, c+1, 1, 0, 0, 0, 0, 16'd12, "s4_cfg_taken");
    push_sig(c+2, c+2, 1, 0, 0, 0, 1, 16'd12, "s4_cfg_promoted");
    push_sig(t+1, t+1, 0, 0, 1, 0, 1, 16'd12, "s4_sync");
    push_sig(t+2, t+4, 1, 0, 1, 0, 1, 16'd12, "s4_gap_only");
    push_sig(t+5, t+6, 1, 0, 0, 0, 1, 16'd12, "s4_idle");
    write_cfg(16'd12, 16'd0, 16'd3, 1'b0);
    step_to(t); pulse_start();
    step_to(t+7);

    // 5: burst 3, gap 0, repeating: SYNC straight after BURST
    c = cyc; t = c + 2;
    push_sig(c+1,  c+1,  1, 0, 0, 0, 0, 16'd12, "s5_cfg_taken");
    push_sig(c+2,  c+2,  1, 0, 0, 0, 1, 16'd12, "s5_cfg_promoted");
    push_sig(t+1,  t+1,  0, 0, 1, 0, 1, 16'd12, "s5_sync");
    push_sig(t+2,  t+4,  1, 1, 1, 0, 1, 16'd12, "s5_burst");
    push_sig(t+5,  t+5,  0, 0, 1, 1, 1, 16'd12, "s5_resync_done");
    push_sig(t+6,  t+8,  1, 1, 1, 0, 1, 16'd12, "s5_burst2");
    push_sig(t+9,  t+9,  1, 0, 0, 1, 1, 16'd12, "s5_stop_idle_done");
    push_sig(t+10, t+10, 1, 0, 0, 0, 1, 16'd12, "s5_idle");
    write_cfg(16'd12, 16'd3, 16'd0, 1'b1);
    step_to(t); pulse_start();
    step_to(t+6); pulse_stop();
    step_to(t+11);

    // 6: reset during GAP
    c = cyc; t = c + 2;
    push_sig(c+1, c+1, 1, 0, 0, 0, 0, 16'd12, "s6_cfg_taken");
    push_sig(c+2, c+2, 1, 0, 0, 0, 1, 16'd12, "s6_cfg_promoted");
    push_sig(t+1, t+1, 0, 0, 1, 0, 1, 16'd12, "s6_sync");
    push_sig(t+2, t+3, 1, 1, 1, 0, 1, 16'd12, "s6_burst");
    push_sig(t+4, t+4, 1, 0, 1, 1, 1, 16'd12, "s6_gap_done");
    push_sig(t+5, t+5, 1, 0, 1, 0, 1, 16'd12, "s6_gap");
    push_sig(t+6, t+6, 0, 0, 0, 0, 1, 16'd4,  "s6_reset_vals");
    push_sig(t+7, t+7, 1, 0, 0, 0, 1, 16'd4,  "s6_idle_after_reset");
    write_cfg(16'd12, 16'd2, 16'd4, 1'b0);
    step_to(t); pulse_start();
    step_to(t+5);
    reset = 1'b1; step(); reset = 1'b0;
    step_to(t+8);

    // 7: start and stop together in IDLE
    c = cyc;
    push_sig(c+1, c+3, 1, 0, 0, 0, 1, 16'd4, "s7_start_stop_idle");
    cmd_start = 1'b1; cmd_stop = 1'b1;
    step();
    cmd_start = 1'b0; cmd_stop = 1'b0;
    step_to(c+4);

`ifdef MOD_BURST_CTRL_BURST_COUNT_EN
    // 8: burst counter over 3 repeated bursts, cleared by a new start
    c = cyc; t = c + 2;
    push_sig(c+1,  c+1,  1, 0, 0, 0, 0, 16'd4, "s8_cfg_taken");
    push_sig(t+1,  t+1,  0, 0, 1, 0, 1, 16'd4, "s8_sync");
    push_bc (t+1,  0, "s8_count_cleared");
    push_sig(t+4,  t+4,  1, 0, 1, 1, 1, 16'd4, "s8_done1");
    push_bc (t+4,  1, "s8_count1");
    push_bc (t+8,  2, "s8_count2");
    push_sig(t+12, t+12, 1, 0, 0, 1, 1, 16'd4, "s8_stop_idle_done");
    push_bc (t+12, 3, "s8_count3");
    push_bc (t+13, 3, "s8_count3_hold");
    push_bc (t+14, 0, "s8_count_restart");
    write_cfg(16'd4, 16'd2, 16'd1, 1'b1);
    step_to(t); pulse_start();
    step_to(t+10); pulse_stop();
    step_to(t+13); pulse_start();
    pulse_stop();
    step_to(t+20);
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
      checks += exp_q.size();
      exp_q.delete();
    end
    step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
